// File: rtl/pixel_stream_reader.sv
// pixel_stream_reader: reads one frame from memory in raster order at a programmable
// pace and emits each pixel as a one-cycle qualified stream beat.
module pixel_stream_reader #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        interval,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_data,
    output logic [3:0]        pixel_out,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_done
);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
    state_t state, next_state;
    logic [3:0] period, timer, p_in;
    logic accept, issue, rd_q, last_q, out_last;
    always_comb begin
        p_in = (interval == 4'd0) ? 4'd1 : interval;
        accept = (state == IDLE) && start;
        issue = (state == STREAM) && (mem_addr != LAST) && (timer == 4'd0);
        next_state = accept ? STREAM :
                     (state == STREAM && mem_addr == LAST) ? DRAIN :
                     (state == DRAIN && out_last) ? IDLE : state;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end
    // rd_q/last_q track reads in flight so the final beat can be recognised in DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            period     <= 4'd1;
            timer      <= 4'd0;
            rd_q       <= 1'b0;
            last_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            pixel_out  <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            mem_rd_en <= accept | issue;
            if (accept) begin
                mem_addr <= '0;
                period   <= p_in;
                timer    <= p_in - 4'd1;
            end else if (issue) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                timer    <= period - 4'd1;
            end else if (timer != 4'd0) begin
                timer <= timer - 4'd1;
            end
            rd_q       <= mem_rd_en;
            last_q     <= mem_rd_en && (mem_addr == LAST);
            out_valid  <= rd_q;
            out_last   <= last_q;
            frame_done <= (state == DRAIN) && out_last;
            if (rd_q) pixel_out <= mem_data;
        end
    end
endmodule

// File: tb/tb_pixel_stream_reader.sv
// tb_pixel_stream_reader: table-driven, directed and random checks of the frame reader
// against a cycle-indexed model derived from start time and pixel period.
module tb_pixel_stream_reader;
    localparam int W = 8, H = 8, AW = 6, N = W * H;
    logic clk = 1'b0, reset, start;
    logic [3:0] interval, mem_data, pixel_out;
    logic mem_rd_en, out_valid, busy, frame_done;
    logic [AW-1:0] mem_addr;
    logic [3:0] mem [N];
    always #5 clk = ~clk;

    pixel_stream_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .interval(interval),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .pixel_out(pixel_out), .out_valid(out_valid), .busy(busy), .frame_done(frame_done)
    );

    // one-cycle read memory; garbage when no read so stray captures are visible
    always @(posedge clk) mem_data <= mem_rd_en ? mem[mem_addr] : 4'($urandom);

    int checks = 0, errors = 0, cyc = 0;
    bit mon_on = 0, act = 0;
    int s = 0, p = 1, dcyc = 0, sc = 0;
    logic [3:0] last_pix = 4'd0;
    logic [AW-1:0] last_addr = '0;
    int n_valid, n_done, n_rd, first_v, prev_v, min_sp, max_sp;

    typedef struct { logic [3:0] iv; int sp; int lat; } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // model: pixel k of a frame started at cycle s is read at s+1+k*p and valid at s+3+k*p
    task automatic monitor();
        int rel, rr;
        logic ev, erd, efd, eb;
        rel = cyc - s - 3;
        rr = cyc - s - 1;
        ev = act && rel >= 0 && rel % p == 0 && rel / p < N;
        erd = act && rr >= 0 && rr % p == 0 && rr / p < N;
        if (ev) last_pix = mem[6'(rel / p)];
        if (erd) last_addr = 6'(rr / p);
        efd = act && cyc == dcyc;
        eb = act && cyc > s && cyc < dcyc;
        if (mon_on) begin
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("pixel_out", 32'(pixel_out), 32'(last_pix));
            chk("mem_rd_en", 32'(mem_rd_en), 32'(erd));
            chk("mem_addr", 32'(mem_addr), 32'(last_addr));
            chk("frame_done", 32'(frame_done), 32'(efd));
            chk("busy", 32'(busy), 32'(eb));
        end
        if (out_valid === 1'b1) begin
            if (n_valid == 0) first_v = cyc;
            else begin
                if (cyc - prev_v < min_sp) min_sp = cyc - prev_v;
                if (cyc - prev_v > max_sp) max_sp = cyc - prev_v;
            end
            prev_v = cyc;
            n_valid++;
        end
        if (frame_done === 1'b1) n_done++;
        if (mem_rd_en === 1'b1) n_rd++;
        if (reset) begin
            act = 0;
            last_pix = 4'd0;
            last_addr = '0;
        end else if (start && (!act || cyc >= dcyc)) begin
            act = 1;
            s = cyc;
            p = (interval == 4'd0) ? 1 : int'(interval);
            dcyc = s + 3 + (N - 1) * p + 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clr();
        n_valid = 0; n_done = 0; n_rd = 0; first_v = -1; prev_v = 0; min_sp = 100000; max_sp = 0;
    endtask

    task automatic pulse_start(input logic [3:0] iv, output int at);
        start = 1'b1;
        interval = iv;
        at = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (frame_done !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        chk("done_timeout", 32'(i < budget), 32'd1);
    endtask

    task automatic wait_valid(input int n, input int budget);
        int i = 0;
        while (n_valid < n && i < budget) begin
            tick();
            i++;
        end
        chk("valid_timeout", 32'(i < budget), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 4'(i % 10);
        tbl[0] = '{4'd4, 4, 3};
        tbl[1] = '{4'd0, 1, 3};
        tbl[2] = '{4'd1, 1, 3};
        tbl[3] = '{4'd2, 2, 3};
        tbl[4] = '{4'd15, 15, 3};
        tbl[5] = '{4'd7, 7, 3};
        reset = 1'b1; start = 1'b0; interval = 4'd0;
        clr();
        tick(); tick();
        mon_on = 1;
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_pixel", 32'(pixel_out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            clr();
            pulse_start(tbl[i].iv, sc);
            wait_done(2000);
            tick();
            chk("tbl_pulses", n_valid, N);
            chk("tbl_done_cnt", n_done, 1);
            chk("tbl_latency", first_v - sc, tbl[i].lat);
            chk("tbl_min_spacing", min_sp, tbl[i].sp);
            chk("tbl_max_spacing", max_sp, tbl[i].sp);
            chk("tbl_busy_after", 32'(busy), 0);
            repeat (3) tick();
        end

        clr();
        pulse_start(4'd4, sc);
        wait_valid(10, 500);
        pulse_start(4'd2, sc);
        wait_done(1000);
        tick();
        chk("restart_pulses", n_valid, N);
        chk("restart_spacing", max_sp, 4);
        chk("restart_spacing_min", min_sp, 4);
        chk("restart_done_cnt", n_done, 1);

        clr();
        pulse_start(4'd1, sc);
        wait_valid(20, 500);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_rd_en", 32'(mem_rd_en), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_pixel", 32'(pixel_out), 0);
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        clr();
        repeat (30) tick();
        chk("abort_no_valid", n_valid, 0);
        chk("abort_no_rd", n_rd, 0);
        pulse_start(4'd4, sc);
        wait_done(1000);
        tick();
        chk("after_abort_pulses", n_valid, N);

        clr();
        pulse_start(4'd1, sc);
        wait_done(500);
        start = 1'b1;
        interval = 4'd3;
        tick();
        start = 1'b0;
        chk("b2b_addr0", 32'(mem_addr), 0);
        chk("b2b_rd_en", 32'(mem_rd_en), 1);
        wait_done(1000);
        tick();
        chk("b2b_pulses", n_valid, 2 * N);
        chk("b2b_done_cnt", n_done, 2);

        reset = 1'b1; start = 1'b1; interval = 4'd5;
        tick();
        reset = 1'b0; start = 1'b0;
        clr();
        repeat (6) tick();
        chk("rst_start_busy", 32'(busy), 0);
        chk("rst_start_no_rd", n_rd, 0);

        for (int i = 0; i < N; i++) mem[i] = 4'($urandom);
        for (int i = 0; i < 5000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 29) == 0);
            interval = 4'($urandom);
            tick();
        end
        reset = 1'b0; start = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pixel_stream_reader.md
PIXEL_STREAM_READER -- requirements
Module: pixel_stream_reader

Interface
REQ-001 Parameter WIDTH, default 640, frame width in pixels.
REQ-002 Parameter HEIGHT, default 480, frame height in pixels.
REQ-003 Parameter ADDR_W, default 19, memory address width; SHALL satisfy 2^ADDR_W >= WIDTH*HEIGHT.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to stream one frame.
REQ-007 interval  input  4  cycles between successive pixel reads, sampled at accepted start; 0 treated as 1.
REQ-008 mem_rd_en  output  1  read strobe to frame memory.
REQ-009 mem_addr  output  ADDR_W  read address, raster order, row*WIDTH+col.
REQ-010 mem_data  input  4  grayscale pixel from memory, valid exactly one cycle after mem_rd_en.
REQ-011 pixel_out  output  4  pixel to edge-detection in port pixel_in.
REQ-012 out_valid  output  1  one-cycle qualifier for pixel_out, drives in_valid.
REQ-013 busy  output  1  high from cycle after accepted start until frame_done.
REQ-014 frame_done  output  1  one-cycle pulse after final pixel emitted.

Function
REQ-015 FSM states IDLE, STREAM, DRAIN; reset enters IDLE.
REQ-016 IDLE: start=1 accepted; latches P = (interval==0 ? 1 : interval); clears pixel counter; enters STREAM.
REQ-017 start while busy=1 SHALL be ignored; latched P unchanged.
REQ-018 STREAM: first read (mem_rd_en=1, mem_addr=0) in cycle after start accepted; subsequent reads every P cycles, address +1 per read.
REQ-019 mem_rd_en SHALL be one-cycle pulse; mem_addr holds last issued value between reads.
REQ-020 Each mem_data SHALL be registered into pixel_out with out_valid=1 one cycle after arrival: read-to-out_valid latency 2 cycles.
REQ-021 pixel_out SHALL hold last value when out_valid=0.
REQ-022 Exactly WIDTH*HEIGHT reads and WIDTH*HEIGHT out_valid pulses per frame, in raster order, no skips or repeats.
REQ-023 Address wrap: after read at WIDTH*HEIGHT-1 no further reads; FSM enters DRAIN.
REQ-024 DRAIN: waits for final out_valid; frame_done=1 next cycle; busy=0 same cycle; enters IDLE.
REQ-025 start accepted in cycle frame_done=1 (IDLE reached) SHALL begin new frame; start during DRAIN ignored.
REQ-026 Pixel counter width ADDR_W; arithmetic unsigned; no overflow for legal parameters.
REQ-027 With P=1, reads and out_valid pulses SHALL be back-to-back every cycle.

Reset
REQ-028 reset=1 SHALL force IDLE and mem_rd_en=0, mem_addr=0, pixel_out=0, out_valid=0, busy=0, frame_done=0 on next edge.
REQ-029 reset mid-frame SHALL abort: no out_valid or mem_rd_en after reset edge, including for reads in flight.
REQ-030 reset and start both high SHALL leave block in IDLE; start ignored.

Verification (WIDTH=8, HEIGHT=8, memory preloaded mem[i]=i%10, 1-cycle read model)
REQ-031 start, interval=4 -> 64 out_valid pulses spaced 4 cycles, pixel_out = 0,1,..,9,0,..; first out_valid 3 cycles after start; frame_done once, busy low after.
REQ-032 start, interval=0 and interval=1 -> identical: 64 consecutive out_valid cycles, mem_addr 0..63, frame_done cycle after last.
REQ-033 start re-pulsed mid-frame with interval=2 -> ignored; spacing stays 4; still exactly 64 pixels.
REQ-034 reset after 20th out_valid -> all outputs 0 next cycle, no further out_valid; new start streams full 64 from address 0.
REQ-035 start asserted in frame_done cycle -> second frame begins, mem_addr=0 next cycle; 128 total pulses, two frame_done.
REQ-036 Chain to edge_detection (thresh=5) -> in_valid count matches 64 per frame; no X on pixel_in.
